// File: rtl/maq_bcd.sv
// Two-digit BCD modulo counter (MIN_VAL..MAX_VAL) with synchronous preset load and cascade carry.
// Define MAQC_DOWN_EN to add the maqc_down port and down-count with wrap to MAX_VAL.
module maq_bcd #(
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 59
) (
    input  logic       maqc_clock,
    input  logic       maqc_reset,
    input  logic       maqc_enable,
    input  logic       maqc_load,
    input  logic [3:0] maqc_load_uni,
    input  logic [3:0] maqc_load_dez,
`ifdef MAQC_DOWN_EN
    input  logic       maqc_down,
`endif
    output logic [3:0] maqc_uni,
    output logic [3:0] maqc_dez,
    output logic       maqc_carry,
    output logic       maqc_load_err
);

    localparam logic [3:0] MIN_UNI = 4'(MIN_VAL % 10);
    localparam logic [3:0] MIN_DEZ = 4'(MIN_VAL / 10);
    localparam logic [3:0] MAX_UNI = 4'(MAX_VAL % 10);
    localparam logic [3:0] MAX_DEZ = 4'(MAX_VAL / 10);

    logic       down;
    logic       at_min;
    logic       at_max;
    logic       terminal;
    logic       digits_ok;
    logic       ge_min;
    logic       le_max;
    logic       load_ok;
    logic [3:0] next_uni;
    logic [3:0] next_dez;

`ifdef MAQC_DOWN_EN
    assign down = maqc_down;
`else
    assign down = 1'b0;
`endif

    assign at_min   = (maqc_dez == MIN_DEZ) && (maqc_uni == MIN_UNI);
    assign at_max   = (maqc_dez == MAX_DEZ) && (maqc_uni == MAX_UNI);
    assign terminal = down ? at_min : at_max;

    assign maqc_carry = maqc_enable & ~maqc_load & ~maqc_reset & terminal;

    // Range check done digit-wise on BCD, so no binary conversion is needed.
    assign digits_ok = (maqc_load_uni <= 4'd9) && (maqc_load_dez <= 4'd9);
    assign ge_min    = (maqc_load_dez > MIN_DEZ) ||
                       ((maqc_load_dez == MIN_DEZ) && (maqc_load_uni >= MIN_UNI));
    assign le_max    = (maqc_load_dez < MAX_DEZ) ||
                       ((maqc_load_dez == MAX_DEZ) && (maqc_load_uni <= MAX_UNI));
    assign load_ok   = digits_ok && ge_min && le_max;

    always_comb begin
        next_uni = maqc_uni;
        next_dez = maqc_dez;
        if (down) begin
            if (at_min) begin
                next_uni = MAX_UNI;
                next_dez = MAX_DEZ;
            end else if (maqc_uni == 4'd0) begin
                next_uni = 4'd9;
                next_dez = maqc_dez - 4'd1;
            end else begin
                next_uni = maqc_uni - 4'd1;
            end
        end else begin
            if (at_max) begin
                next_uni = MIN_UNI;
                next_dez = MIN_DEZ;
            end else if (maqc_uni == 4'd9) begin
                next_uni = 4'd0;
                next_dez = maqc_dez + 4'd1;
            end else begin
                next_uni = maqc_uni + 4'd1;
            end
        end
    end

    always_ff @(posedge maqc_clock) begin
        if (maqc_reset) begin
            maqc_uni      <= MIN_UNI;
            maqc_dez      <= MIN_DEZ;
            maqc_load_err <= 1'b0;
        end else if (maqc_load) begin
            if (load_ok) begin
                maqc_uni <= maqc_load_uni;
                maqc_dez <= maqc_load_dez;
            end
            maqc_load_err <= ~load_ok;
        end else begin
            maqc_load_err <= 1'b0;
            if (maqc_enable) begin
                maqc_uni <= next_uni;
                maqc_dez <= next_dez;
            end
        end
    end

endmodule

// File: tb/tb_maq_bcd.sv
// Scoreboard bench for maq_bcd: six instances (default, 1..12, cascade pair, 0..23, 0..1).
module tb_maq_bcd;

    localparam int N = 6;
    localparam int MINS [N] = '{0, 1, 0, 0, 0, 0};
    localparam int MAXS [N] = '{59, 12, 59, 59, 23, 1};

    logic       clk = 1'b0;
    logic       rst [N];
    logic       en  [N];
    logic       ld  [N];
    logic       dn  [N];
    logic [3:0] lu  [N];
    logic [3:0] ldz [N];
    logic [3:0] uni [N];
    logic [3:0] dez [N];
    logic       carry [N];
    logic       lerr  [N];

    typedef struct {
        int         id;
        string      nm;
        logic [3:0] u;
        logic [3:0] dz;
        logic       c;
        logic       er;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic c_s [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        maq_bcd #(.MIN_VAL(MINS[g]), .MAX_VAL(MAXS[g])) u_dut (
            .maqc_clock   (clk),
            .maqc_reset   (rst[g]),
            .maqc_enable  ((g == 3) ? carry[2] : en[g]),
            .maqc_load    (ld[g]),
            .maqc_load_uni(lu[g]),
            .maqc_load_dez(ldz[g]),
`ifdef MAQC_DOWN_EN
            .maqc_down    (dn[g]),
`endif
            .maqc_uni     (uni[g]),
            .maqc_dez     (dez[g]),
            .maqc_carry   (carry[g]),
            .maqc_load_err(lerr[g])
        );
    end

    task automatic chk(string nm, string fld, logic [3:0] act, logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h at %0t", nm, fld, act, req, $time);
        end
    endtask

    // Monitor: carry sampled mid-cycle (before the edge), digits/err after the edge.
    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < N; i++) c_s[i] = carry[i];
            @(posedge clk);
            #1;
            while (q.size() > 0) begin
                it = q.pop_front();
                chk(it.nm, "carry", {3'b0, c_s[it.id]}, {3'b0, it.c});
                chk(it.nm, "uni", uni[it.id], it.u);
                chk(it.nm, "dez", dez[it.id], it.dz);
                chk(it.nm, "load_err", {3'b0, lerr[it.id]}, {3'b0, it.er});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b0; en[i] = 1'b0; ld[i] = 1'b0; dn[i] = 1'b0;
            lu[i] = 4'd0; ldz[i] = 4'd0;
        end
    endtask

    task automatic drv(int id, bit r, bit l, bit e, bit d, logic [3:0] pu, logic [3:0] pd);
        rst[id] = r; ld[id] = l; en[id] = e; dn[id] = d; lu[id] = pu; ldz[id] = pd;
    endtask

    task automatic expv(int id, string nm, int v, bit c, bit er);
        exp_t it;
        it.id = id; it.nm = nm; it.u = 4'(v % 10); it.dz = 4'(v / 10); it.c = c; it.er = er;
        q.push_back(it);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b1; en[i] = 1'b0; ld[i] = 1'b0; dn[i] = 1'b0; lu[i] = 4'd0; ldz[i] = 4'd0;
        end
        // Reset with everything else idle
        tick();
        for (int i = 0; i < N; i++) drv(i, 1, 0, 0, 0, 0, 0);
        expv(0, "rst0", 0, 0, 0);
        expv(1, "rst1", 1, 0, 0);
        expv(2, "rst2", 0, 0, 0);
        expv(3, "rst3", 0, 0, 0);
        expv(4, "rst4", 0, 0, 0);
        expv(5, "rst5", 0, 0, 0);

        // Default 0..59: 61 enables, carry only at 59, 59->00 then 01
        for (int i = 0; i <= 60; i++) begin
            tick(); drv(0, 0, 0, 1, 0, 0, 0);
            expv(0, "up60", (i + 1) % 60, (i == 59), 0);
        end
        tick(); expv(0, "hold", 1, 0, 0);
        tick(); drv(0, 0, 1, 0, 0, 4'd9, 4'd5); expv(0, "ld59", 59, 0, 0);
        tick(); expv(0, "idle_term", 59, 0, 0);
        tick(); drv(0, 0, 1, 1, 0, 4'd5, 4'd4); expv(0, "ld45_en_term", 45, 0, 0);
        tick(); drv(0, 0, 1, 0, 0, 4'hA, 4'd1); expv(0, "ld_bad_uni", 45, 0, 1);
        tick(); expv(0, "err_clear", 45, 0, 0);
        tick(); drv(0, 0, 1, 0, 0, 4'd0, 4'd6); expv(0, "ld60", 45, 0, 1);
        tick(); drv(0, 0, 1, 1, 0, 4'd7, 4'd3); expv(0, "ld37", 37, 0, 0);
        tick(); drv(0, 1, 1, 1, 0, 4'd5, 4'd4); expv(0, "rst_ld_en", 0, 0, 0);

        // 1..12: 12 enables from 01, wrap 12->01
        for (int k = 1; k <= 12; k++) begin
            tick(); drv(1, 0, 0, 1, 0, 0, 0);
            expv(1, "up12", (k == 12) ? 1 : k + 1, (k == 12), 0);
        end
        tick(); drv(1, 0, 1, 0, 0, 4'd0, 4'd0); expv(1, "ld00_lo", 1, 0, 1);
        tick(); drv(1, 0, 1, 0, 0, 4'd3, 4'd1); expv(1, "ld13_hi", 1, 0, 1);
        tick(); drv(1, 0, 1, 0, 0, 4'd2, 4'd1); expv(1, "ld12", 12, 0, 0);
        tick(); drv(1, 0, 0, 1, 0, 0, 0); expv(1, "wrap12", 1, 1, 0);

        // Cascade 59/59 -> 00/00 on one edge
        tick(); drv(2, 0, 1, 0, 0, 4'd9, 4'd5); drv(3, 0, 1, 0, 0, 4'd9, 4'd5);
        expv(2, "cas_ld_lo", 59, 0, 0); expv(3, "cas_ld_hi", 59, 0, 0);
        tick(); drv(2, 0, 0, 1, 0, 0, 0);
        expv(2, "cas_lo", 0, 1, 0); expv(3, "cas_hi", 0, 1, 0);
        tick(); drv(2, 0, 0, 1, 0, 0, 0);
        expv(2, "cas_lo2", 1, 0, 0); expv(3, "cas_hi2", 0, 0, 0);

        // 0..1: back-to-back wraps
        tick(); drv(5, 0, 0, 1, 0, 0, 0); expv(5, "b2b_a", 1, 0, 0);
        tick(); drv(5, 0, 0, 1, 0, 0, 0); expv(5, "b2b_b", 0, 1, 0);
        tick(); drv(5, 0, 0, 1, 0, 0, 0); expv(5, "b2b_c", 1, 0, 0);
        tick(); drv(5, 0, 0, 1, 0, 0, 0); expv(5, "b2b_d", 0, 1, 0);
        tick(); drv(5, 0, 1, 0, 0, 4'd2, 4'd0); expv(5, "b2b_ld2", 0, 0, 1);

        // 0..23
`ifdef MAQC_DOWN_EN
        tick(); drv(4, 0, 0, 1, 1, 0, 0); expv(4, "dn_wrap", 23, 1, 0);
        tick(); drv(4, 0, 0, 1, 0, 0, 0); expv(4, "up_wrap23", 0, 1, 0);
        tick(); drv(4, 0, 1, 0, 0, 4'd0, 4'd2); expv(4, "ld20", 20, 0, 0);
        tick(); drv(4, 0, 0, 1, 1, 0, 0); expv(4, "dn_borrow", 19, 0, 0);
        tick(); drv(4, 0, 1, 0, 0, 4'd0, 4'd1); expv(4, "ld10", 10, 0, 0);
        tick(); drv(4, 0, 0, 1, 1, 0, 0); expv(4, "tog_a", 9, 0, 0);
        tick(); drv(4, 0, 0, 1, 0, 0, 0); expv(4, "tog_b", 10, 0, 0);
        tick(); drv(4, 0, 0, 1, 1, 0, 0); expv(4, "tog_c", 9, 0, 0);
        tick(); drv(4, 0, 0, 0, 1, 0, 0); expv(4, "dn_idle", 9, 0, 0);
`else
        tick(); drv(4, 0, 0, 1, 0, 0, 0); expv(4, "up1_23", 1, 0, 0);
        tick(); drv(4, 0, 1, 0, 0, 4'd3, 4'd2); expv(4, "ld23", 23, 0, 0);
        tick(); drv(4, 0, 0, 1, 0, 0, 0); expv(4, "up_wrap23", 0, 1, 0);
        tick(); drv(4, 0, 1, 0, 0, 4'd4, 4'd2); expv(4, "ld24", 0, 0, 1);
`endif

        // Drain: bounded wait for the scoreboard to empty
        tick();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
